gcd_dispatch: RTL

Upstream feeder for the `gcd` datapath. It accepts operand pairs on a valid/ready stream, buffers them in a small FIFO and launches one `gcd` job at a time with a `start` pulse. It captures the result on `done` and presents it on a valid/ready result stream. It also short-circuits zero operands and converts a hung job into a tagged error result after a timeout.

---
 rtl/gcd_pkg.sv | 19 +
 rtl/gcd_dispatch_if.sv | 50 +++++
 rtl/gcd_op_fifo.sv | 74 +++++++
 rtl/gcd_dispatch.sv | 129 ++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types for the gcd job dispatcher.
// Operand width, state encoding and default timeout.
package gcd_pkg;

  localparam int GCD_W       = 4;
  localparam int DEF_TIMEOUT = 100;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT
  } state_t;

  typedef struct packed {
    logic [GCD_W-1:0] a;
    logic [GCD_W-1:0] b;
  } op_pair_t;

endpackage

// File: rtl/gcd_dispatch_if.sv
// Operand stream, result stream and gcd job bus.
// slave = dispatcher view, master = environment view.
interface gcd_dispatch_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_err;

  logic             gcd_start;
  logic [WIDTH-1:0] gcd_a;
  logic [WIDTH-1:0] gcd_b;
  logic [WIDTH-1:0] gcd_out;
  logic             gcd_done;
  logic             gcd_busy;

  logic [LW-1:0]    level;
  logic [7:0]       err_cnt;

  modport slave (
    input  in_valid, in_a, in_b,
    input  res_ready,
    input  gcd_out, gcd_done, gcd_busy,
    output in_ready,
    output res_valid, res_data, res_err,
    output gcd_start, gcd_a, gcd_b,
    output level, err_cnt
  );

  modport master (
    output in_valid, in_a, in_b,
    output res_ready,
    output gcd_out, gcd_done, gcd_busy,
    input  in_ready,
    input  res_valid, res_data, res_err,
    input  gcd_start, gcd_a, gcd_b,
    input  level, err_cnt
  );

endinterface

// File: rtl/gcd_op_fifo.sv
// Operand-pair FIFO with wrap-bit pointers.
// full/empty/level are registered.
module gcd_op_fifo
  import gcd_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_i,
  input  logic     pop_i,
  input  op_pair_t wdata_i,
  output op_pair_t rdata_o,
  output logic     full_o,
  output logic     empty_o,
  output logic [LW-1:0] level_o
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  op_pair_t      mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  // a push is refused while full, even alongside a pop
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  // next pointers and flags from the wrap-bit pointers
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (do_push) wptr_d = wptr_q + PTR_ONE;
    if (do_pop)  rptr_d = rptr_q + PTR_ONE;
    level_d = wptr_d - rptr_d;
    empty_d = (wptr_d == rptr_d);
    full_d  = (wptr_d[AW] != rptr_d[AW]) &&
              (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
  end

  // pointer and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // storage, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/gcd_dispatch.sv
// Feeds queued operand pairs to a gcd core one job at a time.
// Zero operands bypass the core; hung jobs time out as errors.
module gcd_dispatch
  import gcd_pkg::*;
#(
  parameter int WIDTH   = GCD_W,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic           clk,
  input logic           rst_n,
  gcd_dispatch_if.slave bus
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_ONE  = {{(TW-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [TW-1:0]    timer_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] res_data_q;
  logic             res_valid_q;
  logic             res_err_q;
  logic             start_q;
  logic [7:0]       err_cnt_q, err_cnt_d;

  op_pair_t         wr_pair, head;
  logic             fifo_full, fifo_empty;
  logic             fifo_push, fifo_pop;
  logic [LW-1:0]    fifo_level;
  logic             head_zero;

  assign wr_pair.a = bus.in_a;
  assign wr_pair.b = bus.in_b;
  assign fifo_push = bus.in_valid && !fifo_full;

  // a new job may start only with an empty result slot and idle core
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty &&
                     !res_valid_q && !bus.gcd_busy;
  assign head_zero = (head.a == '0) || (head.b == '0);

  // error counter sticks at its maximum
  assign err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q
                                          : err_cnt_q + 8'd1;

  gcd_op_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (wr_pair),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // job FSM, timeout timer and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      start_q     <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      start_q <= 1'b0;
      if (res_valid_q && bus.res_ready) begin
        res_valid_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (fifo_pop) begin
            a_q <= head.a;
            b_q <= head.b;
            if (head_zero) begin
              res_data_q  <= head.a | head.b;
              res_err_q   <= 1'b0;
              res_valid_q <= 1'b1;
            end else begin
              start_q <= 1'b1;
              state_q <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          timer_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (bus.gcd_done) begin
            res_data_q  <= bus.gcd_out;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b1;
            state_q     <= IDLE;
          end else if (timer_q == T_LAST) begin
            res_data_q  <= '0;
            res_err_q   <= 1'b1;
            res_valid_q <= 1'b1;
            err_cnt_q   <= err_cnt_d;
            state_q     <= IDLE;
          end else begin
            timer_q <= timer_q + T_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = !fifo_full;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_err   = res_err_q;
  assign bus.gcd_start = start_q;
  assign bus.gcd_a     = a_q;
  assign bus.gcd_b     = b_q;
  assign bus.level     = fifo_level;
  assign bus.err_cnt   = err_cnt_q;

endmodule
